// File: rtl/npu_job_sequencer.sv
// npu_job_sequencer
//   Buffers signed 3-element input vectors and, on a go request, hands them
//   one at a time to an external matrix/activation controller. Each job is
//   a one-cycle ctl_start pulse, then a wait for a rising edge of ctl_done.
//   The result is then held on out_y until the consumer accepts it. A job
//   that never completes trips a sticky err flag and flushes the buffer.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    load handshake; in_x0..2 is the vector (DW, signed)
//   go                   one-cycle request to process everything buffered
//   ctl_start            one-cycle job start to the controller
//   ctl_x0..2            head vector shown to the controller (0 when idle)
//   ctl_done             controller completion level (rising edge = done)
//   ctl_y0..2            controller results (2*DW, signed)
//   out_valid/out_ready  result handshake; out_y0..2 holds the last result
//   busy                 high whenever a batch is in progress
//   err                  sticky controller-timeout flag
module npu_job_sequencer #(
    parameter int DW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_x0,
    input  logic signed [DW-1:0] in_x1,
    input  logic signed [DW-1:0] in_x2,
    input  logic                 go,
    output logic                 ctl_start,
    output logic signed [DW-1:0] ctl_x0,
    output logic signed [DW-1:0] ctl_x1,
    output logic signed [DW-1:0] ctl_x2,
    input  logic                 ctl_done,
    input  logic signed [2*DW-1:0] ctl_y0,
    input  logic signed [2*DW-1:0] ctl_y1,
    input  logic signed [2*DW-1:0] ctl_y2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [2*DW-1:0] out_y0,
    output logic signed [2*DW-1:0] out_y1,
    output logic signed [2*DW-1:0] out_y2,
    output logic                 busy,
    output logic                 err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic signed [DW-1:0] x2;
        logic signed [DW-1:0] x1;
        logic signed [DW-1:0] x0;
    } vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state, state_nx;
    vec_t           mem [DEPTH];
    vec_t           head;
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    logic [TW-1:0]  tcnt;
    logic           done_q;

    logic space, load, pop, done_rise, tmo, flush, capture;

    assign head      = mem[rptr];
    assign space     = (count < CW'(DEPTH));
    assign load      = (state == IDLE) && in_valid && space;
    assign pop       = (state == HOLD) && out_ready;
    // Only a 0->1 transition counts, so a level left high from before the
    // job started cannot complete it.
    assign done_rise = ctl_done && !done_q;
    assign tmo       = (tcnt == TW'(TIMEOUT - 1));
    assign capture   = (state == WAIT) && done_rise;
    // Completion wins over a timeout landing on the same cycle.
    assign flush     = (state == WAIT) && !done_rise && tmo;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        ctl_start = 1'b0;
        ctl_x0    = '0;
        ctl_x1    = '0;
        ctl_x2    = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = space;
                // A vector loaded on the go cycle makes the batch non-empty.
                if (go && ((count != '0) || load)) state_nx = ISSUE;
            end
            ISSUE: begin
                ctl_start = 1'b1;
                ctl_x0    = head.x0;
                ctl_x1    = head.x1;
                ctl_x2    = head.x2;
                state_nx  = WAIT;
            end
            WAIT: begin
                ctl_x0 = head.x0;
                ctl_x1 = head.x1;
                ctl_x2 = head.x2;
                if (done_rise) state_nx = HOLD;
                else if (tmo)  state_nx = IDLE;
            end
            HOLD: begin
                // Go straight to the next job so batches run back to back.
                if (out_ready) state_nx = (count > CW'(1)) ? ISSUE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load) mem[wptr] <= '{x2: in_x2, x1: in_x1, x0: in_x0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            tcnt      <= '0;
            done_q    <= 1'b0;
            out_valid <= 1'b0;
            out_y0    <= '0;
            out_y1    <= '0;
            out_y2    <= '0;
            err       <= 1'b0;
        end else begin
            done_q <= ctl_done;

            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
                err   <= 1'b1;
            end else if (load) begin
                wptr  <= wptr + AW'(1);
                count <= count + CW'(1);
            end else if (pop) begin
                rptr  <= rptr + AW'(1);
                count <= count - CW'(1);
            end

            if (state == ISSUE)     tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + TW'(1);

            if (capture) begin
                out_y0    <= ctl_y0;
                out_y1    <= ctl_y1;
                out_y2    <= ctl_y2;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_npu_job_sequencer.sv
module tb_npu_job_sequencer;
    localparam int DW = 16, DEPTH = 4, TIMEOUT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, in_valid = 1'b0, go = 1'b0, out_ready = 1'b0;
    logic signed [DW-1:0] in_x0 = '0, in_x1 = '0, in_x2 = '0;
    logic in_ready, ctl_start, out_valid, busy, err;
    logic signed [DW-1:0] ctl_x0, ctl_x1, ctl_x2;
    logic ctl_done = 1'b0;
    logic signed [2*DW-1:0] ctl_y0 = '0, ctl_y1 = '0, ctl_y2 = '0;
    logic signed [2*DW-1:0] out_y0, out_y1, out_y2;

    npu_job_sequencer #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .go(go),
        .ctl_start(ctl_start), .ctl_x0(ctl_x0), .ctl_x1(ctl_x1), .ctl_x2(ctl_x2),
        .ctl_done(ctl_done), .ctl_y0(ctl_y0), .ctl_y1(ctl_y1), .ctl_y2(ctl_y2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2), .busy(busy), .err(err)
    );

    int total = 0, bad = 0;

    // Controller behaviour: weights row0 (4,5,6) b0=0, row1 (-1,2,3) b1=-10,
    // row2 (1,1,1) b2=5, followed by ReLU.
    function automatic int ref_row(input int r, input int a, input int b, input int c);
        int v;
        case (r)
            0:       v = 4*a + 5*b + 6*c;
            1:       v = -a + 2*b + 3*c - 10;
            default: v = a + b + c + 5;
        endcase
        return (v < 0) ? 0 : v;
    endfunction

    // Controller model: latches the vector on ctl_start, pulses ctl_done for
    // one cycle after a random latency. dead suppresses the automatic pulse,
    // hold_high pins done high, req_n != ack_n requests a manual pulse.
    bit dead = 0, hold_high = 0;
    int req_n = 0, ack_n = 0, cnt = 0;
    int lx0 = 0, lx1 = 0, lx2 = 0;
    always @(negedge clk) begin
        if (hold_high) ctl_done = 1'b1;
        else if (ctl_done) ctl_done = 1'b0;
        else if (req_n != ack_n) begin ctl_done = 1'b1; ack_n = req_n; end
        else if (cnt > 0) begin cnt--; if (cnt == 0) ctl_done = 1'b1; end
        if (ctl_start) begin
            lx0 = int'(ctl_x0); lx1 = int'(ctl_x1); lx2 = int'(ctl_x2);
            ctl_y0 = (2*DW)'(ref_row(0, lx0, lx1, lx2));
            ctl_y1 = (2*DW)'(ref_row(1, lx0, lx1, lx2));
            ctl_y2 = (2*DW)'(ref_row(2, lx0, lx1, lx2));
            if (!dead) cnt = $urandom_range(1, 4);
        end
    end

    int starts = 0;
    always @(negedge clk) if (ctl_start) starts++;

    // Stimulus bookkeeping: vectors loaded (reference input order) and
    // results observed.
    int vx0[$], vx1[$], vx2[$];
    int oy0[$], oy1[$], oy2[$];

    function automatic int rnd();
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; go = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vx0.delete(); vx1.delete(); vx2.delete();
    endtask

    task automatic load(input int a, input int b, input int c, input bit with_go);
        in_valid = 1'b1; go = with_go;
        in_x0 = DW'(a); in_x1 = DW'(b); in_x2 = DW'(c);
        vx0.push_back(a); vx1.push_back(b); vx2.push_back(c);
        @(negedge clk);
        in_valid = 1'b0; go = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Collects n results with random consumer stalls; no checking here.
    task automatic drain(input int n, input int maxdly, output bit timed_out);
        oy0.delete(); oy1.delete(); oy2.delete();
        timed_out = 0;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!out_valid && w < 200) begin @(negedge clk); w++; end
            if (!out_valid) begin timed_out = 1; return; end
            oy0.push_back(int'(out_y0)); oy1.push_back(int'(out_y1)); oy2.push_back(int'(out_y2));
            repeat ($urandom_range(0, maxdly)) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (ctl_start !== 1'b0) begin bad++; $display("FAIL rst_ctl_start: got %b want 0", ctl_start); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if ({out_y0, out_y1, out_y2} !== '0) begin bad++; $display("FAIL rst_out_y: got %0d,%0d,%0d want 0", out_y0, out_y1, out_y2); end
        total++; if ({ctl_x0, ctl_x1, ctl_x2} !== '0) begin bad++; $display("FAIL rst_ctl_x: got %0d,%0d,%0d want 0", ctl_x0, ctl_x1, ctl_x2); end
    endtask

    task automatic test_single();
        int s0; bit to;
        s0 = starts;
        load(3, 2, 1, 0);
        pulse_go();
        total++; if (ctl_start !== 1'b1 || ctl_x0 !== 16'sd3 || ctl_x1 !== 16'sd2 || ctl_x2 !== 16'sd1) begin
            bad++; $display("FAIL single_issue: got start=%b x=(%0d,%0d,%0d) want 1 (3,2,1)", ctl_start, ctl_x0, ctl_x1, ctl_x2); end
        drain(1, 0, to);
        total++; if (to) begin bad++; $display("FAIL single_wait: got timeout want result"); end
        else begin
            total++; if (oy0[0] !== 28 || oy1[0] !== 0 || oy2[0] !== 11) begin
                bad++; $display("FAIL single_y: got (%0d,%0d,%0d) want (28,0,11)", oy0[0], oy1[0], oy2[0]); end
        end
        repeat (2) @(negedge clk);
        total++; if (starts - s0 !== 1) begin bad++; $display("FAIL single_starts: got %0d want 1", starts - s0); end
        total++; if (out_y0 !== 28) begin bad++; $display("FAIL single_retain: got %0d want 28", out_y0); end
        vx0.delete(); vx1.delete(); vx2.delete();
    endtask

    task automatic test_two();
        int s0; bit to;
        s0 = starts;
        load(3, 2, 1, 0);
        load(4, 4, -1, 0);
        pulse_go();
        drain(2, 0, to);
        total++; if (to) begin bad++; $display("FAIL two_wait: got timeout want 2 results"); end
        else begin
            total++; if (oy0[0] !== 28 || oy1[0] !== 0 || oy2[0] !== 11) begin
                bad++; $display("FAIL two_y0: got (%0d,%0d,%0d) want (28,0,11)", oy0[0], oy1[0], oy2[0]); end
            total++; if (oy0[1] !== 30 || oy1[1] !== 0 || oy2[1] !== 12) begin
                bad++; $display("FAIL two_y1: got (%0d,%0d,%0d) want (30,0,12)", oy0[1], oy1[1], oy2[1]); end
        end
        repeat (2) @(negedge clk);
        total++; if (starts - s0 !== 2) begin bad++; $display("FAIL two_starts: got %0d want 2", starts - s0); end
        vx0.delete(); vx1.delete(); vx2.delete();
    endtask

    task automatic test_full();
        bit to;
        for (int i = 0; i < DEPTH; i++) load(rnd(), rnd(), rnd(), 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        pulse_go();
        drain(DEPTH, 2, to);
        total++; if (to) begin bad++; $display("FAIL full_wait: got timeout want %0d results", DEPTH); end
        else for (int i = 0; i < DEPTH; i++) begin
            int a, b, c;
            a = vx0.pop_front(); b = vx1.pop_front(); c = vx2.pop_front();
            total++; if (oy0[i] !== ref_row(0, a, b, c) || oy1[i] !== ref_row(1, a, b, c) || oy2[i] !== ref_row(2, a, b, c)) begin
                bad++; $display("FAIL full_y[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, oy0[i], oy1[i], oy2[i],
                                ref_row(0, a, b, c), ref_row(1, a, b, c), ref_row(2, a, b, c)); end
        end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL full_idle: got ready=%b busy=%b want 1 0", in_ready, busy); end
        vx0.delete(); vx1.delete(); vx2.delete();
    endtask

    task automatic test_go_edges();
        int s0; bit to;
        s0 = starts;
        pulse_go();
        total++; if (busy !== 1'b0 || starts !== s0) begin bad++; $display("FAIL go_empty: got busy=%b starts+%0d want 0 0", busy, starts - s0); end
        load(7, -3, 2, 1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL go_with_load: got busy=%b want 1", busy); end
        drain(1, 1, to);
        total++; if (to || oy0[0] !== ref_row(0, 7, -3, 2) || oy1[0] !== ref_row(1, 7, -3, 2) || oy2[0] !== ref_row(2, 7, -3, 2)) begin
            bad++; $display("FAIL go_with_load_y: got to=%b y0=%0d want to=0 y0=%0d", to, (oy0.size() > 0) ? oy0[0] : -1, ref_row(0, 7, -3, 2)); end
        vx0.delete(); vx1.delete(); vx2.delete();
    endtask

    task automatic test_backpressure();
        int w, h0, h1, h2, s0; bit to;
        int a, b, c;
        load(rnd(), rnd(), rnd(), 0);
        load(rnd(), rnd(), rnd(), 0);
        pulse_go();
        w = 0;
        while (!out_valid && w < 200) begin @(negedge clk); w++; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_first: got out_valid=%b want 1", out_valid); end
        h0 = int'(out_y0); h1 = int'(out_y1); h2 = int'(out_y2);
        a = vx0.pop_front(); b = vx1.pop_front(); c = vx2.pop_front();
        total++; if (h0 !== ref_row(0, a, b, c) || h1 !== ref_row(1, a, b, c) || h2 !== ref_row(2, a, b, c)) begin
            bad++; $display("FAIL bp_y0: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", h0, h1, h2, ref_row(0, a, b, c), ref_row(1, a, b, c), ref_row(2, a, b, c)); end
        s0 = starts;
        go = 1'b1;   // go while busy must be ignored
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            go = 1'b0;
            total++; if (out_valid !== 1'b1 || ctl_start !== 1'b0 || int'(out_y0) !== h0 || int'(out_y1) !== h1 || int'(out_y2) !== h2) begin
                bad++; $display("FAIL bp_hold[%0d]: got valid=%b start=%b y0=%0d want 1 0 %0d", i, out_valid, ctl_start, out_y0, h0); end
        end
        total++; if (starts !== s0) begin bad++; $display("FAIL bp_starts: got +%0d want +0", starts - s0); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (ctl_start !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got start=%b valid=%b want 1 0", ctl_start, out_valid); end
        drain(1, 0, to);
        a = vx0.pop_front(); b = vx1.pop_front(); c = vx2.pop_front();
        total++; if (to || oy0[0] !== ref_row(0, a, b, c) || oy2[0] !== ref_row(2, a, b, c)) begin
            bad++; $display("FAIL bp_y1: got to=%b y0=%0d want to=0 y0=%0d", to, (oy0.size() > 0) ? oy0[0] : -1, ref_row(0, a, b, c)); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n, s0; bit to, cogo;
            n = $urandom_range(1, DEPTH);
            cogo = $urandom_range(0, 1);
            s0 = starts;
            for (int i = 0; i < n; i++) load(rnd(), rnd(), rnd(), cogo && (i == n - 1));
            if (!cogo) pulse_go();
            drain(n, 3, to);
            total++; if (to) begin bad++; $display("FAIL rand[%0d]_wait: got timeout want %0d results", r, n); end
            else for (int i = 0; i < n; i++) begin
                int a, b, c;
                a = vx0.pop_front(); b = vx1.pop_front(); c = vx2.pop_front();
                total++; if (oy0[i] !== ref_row(0, a, b, c) || oy1[i] !== ref_row(1, a, b, c) || oy2[i] !== ref_row(2, a, b, c)) begin
                    bad++; $display("FAIL rand[%0d]_y[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", r, i, oy0[i], oy1[i], oy2[i],
                                    ref_row(0, a, b, c), ref_row(1, a, b, c), ref_row(2, a, b, c)); end
            end
            repeat (2) @(negedge clk);
            total++; if (starts - s0 !== n) begin bad++; $display("FAIL rand[%0d]_starts: got %0d want %0d", r, starts - s0, n); end
            vx0.delete(); vx1.delete(); vx2.delete();
        end
    endtask

    task automatic test_level();
        int w;
        dead = 1; hold_high = 1;
        @(negedge clk);
        load(5, 1, -2, 0);
        pulse_go();
        repeat (6) @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL level_high: got valid=%b busy=%b want 0 1", out_valid, busy); end
        hold_high = 0;
        repeat (2) @(negedge clk);
        req_n++;
        w = 0;
        while (!out_valid && w < 10) begin @(negedge clk); w++; end
        total++; if (out_valid !== 1'b1 || int'(out_y0) !== ref_row(0, 5, 1, -2) || int'(out_y2) !== ref_row(2, 5, 1, -2)) begin
            bad++; $display("FAIL level_edge: got valid=%b y0=%0d want 1 %0d", out_valid, out_y0, ref_row(0, 5, 1, -2)); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        dead = 0;
        vx0.delete(); vx1.delete(); vx2.delete();
    endtask

    task automatic test_timeout();
        int s0;
        dead = 1;
        for (int i = 0; i < DEPTH; i++) load(rnd(), rnd(), rnd(), 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL tmo_full: got in_ready=%b want 0", in_ready); end
        pulse_go();
        total++; if (ctl_start !== 1'b1) begin bad++; $display("FAIL tmo_issue: got start=%b want 1", ctl_start); end
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k == TIMEOUT) begin
                total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early: got err=%b busy=%b want 0 1", err, busy); end
            end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", err); end
        total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL tmo_flush: got busy=%b ready=%b valid=%b want 0 1 0", busy, in_ready, out_valid); end
        s0 = starts;
        pulse_go();
        @(negedge clk);
        total++; if (busy !== 1'b0 || starts !== s0 || err !== 1'b1) begin
            bad++; $display("FAIL tmo_go_empty: got busy=%b starts+%0d err=%b want 0 0 1", busy, starts - s0, err); end
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear: got %b want 0", err); end
        dead = 0;
    endtask

    task automatic test_reset_mid_wait();
        int s0; bit seen;
        dead = 1;
        load(9, 8, 7, 0);
        load(1, 1, 1, 0);
        pulse_go();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmw_busy: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || ctl_start !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL rmw_ctrl: got busy=%b ready=%b valid=%b start=%b err=%b want 0 1 0 0 0", busy, in_ready, out_valid, ctl_start, err); end
        total++; if ({ctl_x0, ctl_x1, ctl_x2, out_y0, out_y1, out_y2} !== '0) begin
            bad++; $display("FAIL rmw_data: got x0=%0d y0=%0d want 0 0", ctl_x0, out_y0); end
        req_n++;
        seen = 0;
        repeat (5) begin @(negedge clk); if (out_valid) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmw_late_done: got out_valid=1 want 0"); end
        s0 = starts;
        pulse_go();
        @(negedge clk);
        total++; if (busy !== 1'b0 || starts !== s0) begin bad++; $display("FAIL rmw_discard: got busy=%b starts+%0d want 0 0", busy, starts - s0); end
        dead = 0;
        vx0.delete(); vx1.delete(); vx2.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_full();
        test_go_edges();
        test_backpressure();
        test_random();
        test_level();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/npu_job_sequencer.md
NPU_JOB_SEQUENCER -- requirements
Module: npu_job_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed element width of input vectors.
REQ-002 SHALL have parameter DEPTH, default 4, meaning input-vector buffer slots (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning max cycles waiting for ctl_done per job.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have these ports:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  load-side vector valid
  in_ready  out  1  load-side accept
  in_x0, in_x1, in_x2  in  DW each  signed input vector
  go  in  1  one-cycle request to process all buffered vectors
  ctl_start  out  1  start pulse to controller
  ctl_x0, ctl_x1, ctl_x2  out  DW each  vector presented to controller
  ctl_done  in  1  controller completion (level)
  ctl_y0, ctl_y1, ctl_y2  in  2*DW each  controller results
  out_valid  out  1  result valid
  out_ready  in  1  result accept
  out_y0, out_y1, out_y2  out  2*DW each  captured results
  busy  out  1  high in any state but IDLE
  err  out  1  sticky timeout flag
- Weights and biases are driven to the controller by the enclosing top level, not by this block.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, HOLD.
REQ-007 IDLE: in_ready = (count < DEPTH); load on in_valid&&in_ready; FIFO order; count increments.
REQ-008 Outside IDLE: in_ready SHALL be 0 and loads SHALL NOT occur.
REQ-009 IDLE with go=1 and count>0 -> ISSUE; go with count=0 SHALL be ignored; go outside IDLE SHALL be ignored.
REQ-010 Simultaneous go and accepted load in IDLE: the vector SHALL be stored, and processing SHALL include it.
REQ-011 ISSUE: ctl_start=1 for exactly one cycle; next state WAIT; timeout counter cleared.
REQ-012 ctl_x0..2 SHALL equal the head buffer entry from ISSUE through WAIT, held stable; 0 in IDLE.
REQ-013 WAIT: a job completes on a rising edge of ctl_done (registered previous sample 0, current 1); a level already high on entry SHALL NOT complete the job.
REQ-014 On completion, ctl_y0..2 SHALL be captured into out_y0..2 on the same edge; out_valid=1; state HOLD.
REQ-015 HOLD: out_y stable while out_valid && !out_ready; on out_ready, pop head, count decrements, out_valid=0.
REQ-016 HOLD exit: count after pop >0 -> ISSUE, else -> IDLE; back-to-back jobs SHALL have no extra idle cycles.
REQ-017 WAIT timeout: after TIMEOUT cycles without completion, err=1 (sticky until rst), buffer flushed (count=0), state IDLE, out_valid stays 0.
REQ-018 Buffer pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-019 out_y SHALL retain the last captured values after out_valid drops.

Reset
REQ-020 rst SHALL force IDLE, count=0, pointers=0, ctl_start=0, ctl_x=0, out_valid=0, out_y=0, err=0, busy=0, done-edge register=0.
REQ-021 rst in any state, including mid-WAIT or HOLD, SHALL abort the job and discard buffered vectors and any pending result.

Verification
REQ-022 Controller weights row0 (4,5,6) b0=0, row1 (-1,2,3) b1=-10, row2 (1,1,1) b2=5; load (3,2,1), go -> one ctl_start pulse, out (28,0,11).
REQ-023 Same weights; load (3,2,1) then (4,4,-1), go, out_ready=1 -> results (28,0,11) then (30,0,12) in order; exactly 2 start pulses.
REQ-024 Load DEPTH vectors -> in_ready=0 on the cycle after the last load; go -> all DEPTH results returned; count=0; in_ready=1 in IDLE.
REQ-025 out_ready held 0 for 10 cycles in HOLD -> out_y stable, no new ctl_start; release -> next job issues on the following cycle.
REQ-026 Controller model never raises done -> err=1 exactly TIMEOUT cycles after entering WAIT; state IDLE; count=0; go with empty buffer ignored.
REQ-027 rst asserted mid-WAIT -> next cycle all outputs at reset values; a late ctl_done edge produces no out_valid.
